// File: rtl/ahf_mbox_link.sv
// Multi-channel CPU<->link mailbox: per-channel TX/RX FIFOs behind a memory-mapped window,
// four-phase valid/done link handshake with round-robin TX arbitration.
module ahf_mbox_link #(
    parameter int         DW    = 14,
    parameter int         NCH   = 2,
    parameter int         DEPTH = 4,
    parameter logic [7:0] BASE  = 8'h3F
) (
    input  logic          Clk_pin,
    input  logic          Reset_pin,
    input  logic [DW-1:0] cpu_addr,
    input  logic          cpu_wr,
    input  logic          cpu_rd,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    output logic [DW-1:0] link_tx_data,
    output logic [2:0]    link_tx_ch,
    output logic          link_tx_valid,
    input  logic          link_tx_done,
    input  logic [DW-1:0] link_rx_data,
    input  logic [2:0]    link_rx_ch,
    input  logic          link_rx_valid,
    output logic          link_rx_done,
    output logic          irq
);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {TX_IDLE, TX_REQ, TX_WAIT_LOW} tx_st_t;
    typedef enum logic {RX_IDLE, RX_ACK} rx_st_t;

    logic [DW-1:0]  r_tx_mem [NCH][DEPTH];
    logic [DW-1:0]  r_rx_mem [NCH][DEPTH];
    logic [PW-1:0]  r_tx_wp [NCH];
    logic [PW-1:0]  r_tx_rp [NCH];
    logic [PW-1:0]  r_rx_wp [NCH];
    logic [PW-1:0]  r_rx_rp [NCH];
    logic [CW-1:0]  r_tx_cnt [NCH];
    logic [CW-1:0]  r_rx_cnt [NCH];
    logic [NCH-1:0] r_mask;
    logic [DW-1:0]  r_rdata;
    logic           r_irq;
    tx_st_t         r_tx_st;
    logic [CHW-1:0] r_tx_ch;
    logic [DW-1:0]  r_tx_data;
    logic           r_tx_valid;
    logic [CHW-1:0] r_rr;
    rx_st_t         r_rx_st;
    logic           r_rx_done;

    logic [NCH-1:0] w_tx_full, w_tx_nempty, w_rx_full, w_rx_nempty;
    logic [NCH-1:0] w_is_data, w_is_stat;
    logic [NCH-1:0] w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
    logic           w_sel, w_stall, w_rd_en, w_mask_wr, w_rx_ch_ok, w_rx_accept, w_tx_any;
    logic [7:0]     w_off;
    logic [DW-1:0]  w_rd_val;
    logic [CHW-1:0] w_tx_pick;
    int             w_idx;

    // Offset 0xF belongs to another block, so it is excluded from selection entirely.
    assign w_off = cpu_addr[7:0];
    assign w_sel = (cpu_addr[DW-1:8] == BASE[DW-9:0]) && (w_off != 8'h0F);

    always_comb begin
        w_tx_full   = '0;
        w_tx_nempty = '0;
        w_rx_full   = '0;
        w_rx_nempty = '0;
        w_is_data   = '0;
        w_is_stat   = '0;
        for (int c = 0; c < NCH; c++) begin
            w_tx_full[c]   = (r_tx_cnt[c] == CW'(DEPTH));
            w_tx_nempty[c] = (r_tx_cnt[c] != '0);
            w_rx_full[c]   = (r_rx_cnt[c] == CW'(DEPTH));
            w_rx_nempty[c] = (r_rx_cnt[c] != '0);
            w_is_data[c]   = w_sel && (w_off == 8'(2 * c));
            w_is_stat[c]   = w_sel && (w_off == 8'(2 * c + 1));
        end
    end

    assign w_stall   = |(w_is_data & (({NCH{cpu_wr}} & w_tx_full) | ({NCH{cpu_rd}} & ~w_rx_nempty)));
    assign w_tx_push = w_is_data & {NCH{cpu_wr & ~w_stall}};
    assign w_rx_pop  = w_is_data & {NCH{cpu_rd & ~w_stall}};
    assign w_rd_en   = w_sel && cpu_rd && !w_stall;
    assign w_mask_wr = w_sel && cpu_wr && (w_off == 8'h0E);

    always_comb begin
        w_rd_val = '0;
        for (int c = 0; c < NCH; c++) begin
            if (w_is_data[c]) w_rd_val = r_rx_mem[c][r_rx_rp[c]];
            if (w_is_stat[c]) begin
                w_rd_val[0]   = w_rx_nempty[c];
                w_rd_val[1]   = !w_tx_full[c];
                w_rd_val[5:2] = 4'(r_rx_cnt[c]);
                w_rd_val[9:6] = 4'(r_tx_cnt[c]);
            end
        end
        if (w_sel && (w_off == 8'h0E)) w_rd_val[NCH-1:0] = r_mask;
    end

    // Descending scan so the smallest distance from r_rr wins.
    always_comb begin
        w_tx_any  = 1'b0;
        w_tx_pick = '0;
        w_idx     = 0;
        for (int k = NCH - 1; k >= 0; k--) begin
            w_idx = int'(r_rr) + k;
            if (w_idx >= NCH) w_idx = w_idx - NCH;
            if (w_tx_nempty[w_idx]) begin
                w_tx_any  = 1'b1;
                w_tx_pick = CHW'(w_idx);
            end
        end
    end

    assign w_rx_ch_ok = (link_rx_ch < 3'(NCH));

    always_comb begin
        w_tx_pop  = '0;
        w_rx_push = '0;
        for (int c = 0; c < NCH; c++) begin
            w_tx_pop[c]  = (r_tx_st == TX_REQ) && link_tx_done && (r_tx_ch == CHW'(c));
            w_rx_push[c] = (r_rx_st == RX_IDLE) && link_rx_valid &&
                           (link_rx_ch == 3'(c)) && !w_rx_full[c];
        end
    end

    assign w_rx_accept = (r_rx_st == RX_IDLE) && link_rx_valid && (!w_rx_ch_ok || (|w_rx_push));

    always_ff @(posedge Clk_pin) begin
        for (int c = 0; c < NCH; c++) begin
            if (w_tx_push[c]) r_tx_mem[c][r_tx_wp[c]] <= cpu_wdata;
            if (w_rx_push[c]) r_rx_mem[c][r_rx_wp[c]] <= link_rx_data;
        end
    end

    always_ff @(posedge Clk_pin) begin
        if (Reset_pin) begin
            for (int c = 0; c < NCH; c++) begin
                r_tx_wp[c]  <= '0;
                r_tx_rp[c]  <= '0;
                r_rx_wp[c]  <= '0;
                r_rx_rp[c]  <= '0;
                r_tx_cnt[c] <= '0;
                r_rx_cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (w_tx_push[c]) r_tx_wp[c] <= r_tx_wp[c] + 1'b1;
                if (w_tx_pop[c])  r_tx_rp[c] <= r_tx_rp[c] + 1'b1;
                if (w_rx_push[c]) r_rx_wp[c] <= r_rx_wp[c] + 1'b1;
                if (w_rx_pop[c])  r_rx_rp[c] <= r_rx_rp[c] + 1'b1;
                r_tx_cnt[c] <= r_tx_cnt[c] + CW'(w_tx_push[c]) - CW'(w_tx_pop[c]);
                r_rx_cnt[c] <= r_rx_cnt[c] + CW'(w_rx_push[c]) - CW'(w_rx_pop[c]);
            end
        end
    end

    always_ff @(posedge Clk_pin) begin
        if (Reset_pin) begin
            r_rdata <= '0;
            r_mask  <= '0;
            r_irq   <= 1'b0;
        end else begin
            if (w_rd_en)   r_rdata <= w_rd_val;
            if (w_mask_wr) r_mask  <= cpu_wdata[NCH-1:0];
            r_irq <= |(w_rx_nempty & r_mask);
        end
    end

    always_ff @(posedge Clk_pin) begin
        if (Reset_pin) begin
            r_tx_st    <= TX_IDLE;
            r_tx_ch    <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_rr       <= '0;
        end else begin
            case (r_tx_st)
                TX_IDLE: begin
                    if (w_tx_any) begin
                        r_tx_ch    <= w_tx_pick;
                        r_tx_data  <= r_tx_mem[w_tx_pick][r_tx_rp[w_tx_pick]];
                        r_tx_valid <= 1'b1;
                        r_tx_st    <= TX_REQ;
                    end
                end
                TX_REQ: begin
                    if (link_tx_done) begin
                        r_tx_valid <= 1'b0;
                        r_rr       <= (r_tx_ch == CHW'(NCH - 1)) ? '0 : r_tx_ch + 1'b1;
                        r_tx_st    <= TX_WAIT_LOW;
                    end
                end
                TX_WAIT_LOW: begin
                    if (!link_tx_done) r_tx_st <= TX_IDLE;
                end
                default: r_tx_st <= TX_IDLE;
            endcase
        end
    end

    // Words on out-of-range channels are acknowledged and dropped so the remote never hangs.
    always_ff @(posedge Clk_pin) begin
        if (Reset_pin) begin
            r_rx_st   <= RX_IDLE;
            r_rx_done <= 1'b0;
        end else begin
            case (r_rx_st)
                RX_IDLE: begin
                    if (w_rx_accept) begin
                        r_rx_done <= 1'b1;
                        r_rx_st   <= RX_ACK;
                    end
                end
                RX_ACK: begin
                    if (!link_rx_valid) begin
                        r_rx_done <= 1'b0;
                        r_rx_st   <= RX_IDLE;
                    end
                end
                default: r_rx_st <= RX_IDLE;
            endcase
        end
    end

    assign cpu_rdata     = r_rdata;
    assign cpu_stall     = w_stall;
    assign link_tx_data  = r_tx_data;
    assign link_tx_ch    = 3'(r_tx_ch);
    assign link_tx_valid = r_tx_valid;
    assign link_rx_done  = r_rx_done;
    assign irq           = r_irq;
endmodule

// File: tb/tb_ahf_mbox_link.sv
// Directed bench for ahf_mbox_link: CPU window accesses, stalls, link handshakes, irq and reset.
module tb_ahf_mbox_link;
    logic        Clk_pin, Reset_pin;
    logic [13:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_wr, cpu_rd, cpu_stall;
    logic [13:0] link_tx_data, link_rx_data;
    logic [2:0]  link_tx_ch, link_rx_ch;
    logic        link_tx_valid, link_tx_done, link_rx_valid, link_rx_done, irq;

    int n_chk = 0;
    int n_fail = 0;

    ahf_mbox_link #(.DW(14), .NCH(2), .DEPTH(4), .BASE(8'h3F)) dut (
        .Clk_pin(Clk_pin), .Reset_pin(Reset_pin),
        .cpu_addr(cpu_addr), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .link_tx_data(link_tx_data), .link_tx_ch(link_tx_ch), .link_tx_valid(link_tx_valid),
        .link_tx_done(link_tx_done),
        .link_rx_data(link_rx_data), .link_rx_ch(link_rx_ch), .link_rx_valid(link_rx_valid),
        .link_rx_done(link_rx_done), .irq(irq)
    );

    initial Clk_pin = 1'b0;
    always #5 Clk_pin = ~Clk_pin;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cpu_write(input logic [13:0] a, input logic [13:0] d, output int stalls);
        int n;
        @(negedge Clk_pin);
        cpu_addr = a; cpu_wdata = d; cpu_wr = 1'b1;
        #1;
        n = 0;
        while (cpu_stall && n < 200) begin @(negedge Clk_pin); #1; n++; end
        n_chk++;
        if (cpu_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL write_timeout addr=%h stall=%b required 0", a, cpu_stall);
        end
        stalls = n;
        @(posedge Clk_pin); #1;
        cpu_wr = 1'b0;
    endtask

    task automatic cpu_read(input logic [13:0] a, output logic [13:0] d, output int stalls);
        int n;
        @(negedge Clk_pin);
        cpu_addr = a; cpu_rd = 1'b1;
        #1;
        n = 0;
        while (cpu_stall && n < 200) begin @(negedge Clk_pin); #1; n++; end
        n_chk++;
        if (cpu_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL read_timeout addr=%h stall=%b required 0", a, cpu_stall);
        end
        stalls = n;
        @(posedge Clk_pin); #1;
        d = cpu_rdata;
        cpu_rd = 1'b0;
    endtask

    task automatic tx_accept(output logic [13:0] d, output logic [2:0] ch, input int dly);
        int n;
        n = 0;
        while (!link_tx_valid && n < 200) begin @(negedge Clk_pin); n++; end
        n_chk++;
        if (link_tx_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL tx_valid_timeout valid=%b required 1", link_tx_valid);
        end
        d = link_tx_data; ch = link_tx_ch;
        repeat (dly) @(negedge Clk_pin);
        @(negedge Clk_pin);
        link_tx_done = 1'b1;
        n = 0;
        while (link_tx_valid && n < 200) begin @(negedge Clk_pin); n++; end
        n_chk++;
        if (link_tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL tx_drop_timeout valid=%b required 0", link_tx_valid);
        end
        link_tx_done = 1'b0;
    endtask

    task automatic rx_send(input logic [13:0] d, input logic [2:0] ch, output int wc, output logic irq_at_done);
        int n;
        @(negedge Clk_pin);
        link_rx_data = d; link_rx_ch = ch; link_rx_valid = 1'b1;
        n = 0;
        while (!link_rx_done && n < 200) begin @(negedge Clk_pin); n++; end
        n_chk++;
        if (link_rx_done !== 1'b1) begin
            n_fail++;
            $display("FAIL rx_done_timeout done=%b required 1", link_rx_done);
        end
        wc = n; irq_at_done = irq;
        link_rx_valid = 1'b0;
        n = 0;
        while (link_rx_done && n < 200) begin @(negedge Clk_pin); n++; end
        n_chk++;
        if (link_rx_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rx_done_drop_timeout done=%b required 0", link_rx_done);
        end
    endtask

    task automatic test_reset();
        logic [13:0] d;
        int st;
        Reset_pin = 1'b1;
        repeat (3) @(posedge Clk_pin);
        @(negedge Clk_pin);
        Reset_pin = 1'b0;
        #1;
        n_chk++;
        if ({cpu_rdata, link_tx_data, link_tx_ch, link_tx_valid, link_rx_done, irq, cpu_stall} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs rdata=%h txd=%h txch=%h v=%b rd=%b irq=%b stall=%b required all 0",
                     cpu_rdata, link_tx_data, link_tx_ch, link_tx_valid, link_rx_done, irq, cpu_stall);
        end
        cpu_read(14'h3F01, d, st);
        n_chk++;
        if (d !== 14'h0002 || st != 0) begin
            n_fail++; $display("FAIL reset_stat0 got=%h stalls=%0d required 0002 stalls 0", d, st);
        end
        cpu_read(14'h3F03, d, st);
        n_chk++;
        if (d !== 14'h0002) begin n_fail++; $display("FAIL reset_stat1 got=%h required 0002", d); end
        cpu_read(14'h1234, d, st);
        n_chk++;
        if (d !== 14'h0002) begin n_fail++; $display("FAIL unselected_hold got=%h required 0002", d); end
        cpu_read(14'h3F20, d, st);
        n_chk++;
        if (d !== 14'h0000) begin n_fail++; $display("FAIL window_other got=%h required 0000", d); end
        cpu_read(14'h3F0E, d, st);
        n_chk++;
        if (d !== 14'h0000) begin n_fail++; $display("FAIL reset_mask got=%h required 0000", d); end
    endtask

    task automatic test_tx_basic();
        logic [13:0] d;
        logic [2:0]  ch;
        int st;
        cpu_write(14'h3F00, 14'h1234, st);
        cpu_write(14'h3F00, 14'h0ABC, st);
        tx_accept(d, ch, 2);
        n_chk++;
        if (d !== 14'h1234 || ch !== 3'd0) begin
            n_fail++; $display("FAIL tx_word0 got=%h/ch%0d required 1234/ch0", d, ch);
        end
        tx_accept(d, ch, 2);
        n_chk++;
        if (d !== 14'h0ABC || ch !== 3'd0) begin
            n_fail++; $display("FAIL tx_word1 got=%h/ch%0d required 0ABC/ch0", d, ch);
        end
        repeat (3) @(negedge Clk_pin);
        cpu_read(14'h3F01, d, st);
        n_chk++;
        if (d !== 14'h0002) begin n_fail++; $display("FAIL tx_stat0_after got=%h required 0002", d); end
    endtask

    task automatic test_tx_stall();
        logic [13:0] d;
        logic [2:0]  ch;
        int st;
        int st5;
        for (int i = 0; i < 4; i++) cpu_write(14'h3F02, 14'h0100 + 14'(i), st);
        cpu_read(14'h3F03, d, st);
        n_chk++;
        if (d !== 14'h0100) begin n_fail++; $display("FAIL tx1_full_stat got=%h required 0100", d); end
        fork
            cpu_write(14'h3F02, 14'h0104, st5);
            begin
                repeat (5) @(negedge Clk_pin);
                tx_accept(d, ch, 0);
            end
        join
        n_chk++;
        if (st5 < 5) begin n_fail++; $display("FAIL tx_full_stall stall_cycles=%0d required >=5", st5); end
        n_chk++;
        if (d !== 14'h0100 || ch !== 3'd1) begin
            n_fail++; $display("FAIL tx1_first got=%h/ch%0d required 0100/ch1", d, ch);
        end
        for (int i = 1; i < 5; i++) begin
            tx_accept(d, ch, 1);
            n_chk++;
            if (d !== 14'h0100 + 14'(i) || ch !== 3'd1) begin
                n_fail++; $display("FAIL tx1_drain%0d got=%h/ch%0d required %h/ch1", i, d, ch, 14'h0100 + 14'(i));
            end
        end
        repeat (3) @(negedge Clk_pin);
        cpu_read(14'h3F03, d, st);
        n_chk++;
        if (d !== 14'h0002) begin n_fail++; $display("FAIL tx1_stat_after got=%h required 0002", d); end
    endtask

    task automatic test_round_robin();
        logic [13:0] d;
        logic [2:0]  ch;
        logic [13:0] exp_d [4];
        logic [2:0]  exp_c [4];
        int st;
        exp_d = '{14'h00A0, 14'h00B0, 14'h00A1, 14'h00B1};
        exp_c = '{3'd0, 3'd1, 3'd0, 3'd1};
        cpu_write(14'h3F00, 14'h00A0, st);
        cpu_write(14'h3F00, 14'h00A1, st);
        cpu_write(14'h3F02, 14'h00B0, st);
        cpu_write(14'h3F02, 14'h00B1, st);
        for (int i = 0; i < 4; i++) begin
            tx_accept(d, ch, 1);
            n_chk++;
            if (d !== exp_d[i] || ch !== exp_c[i]) begin
                n_fail++; $display("FAIL rr_order%0d got=%h/ch%0d required %h/ch%0d", i, d, ch, exp_d[i], exp_c[i]);
            end
        end
    endtask

    task automatic test_rx_irq();
        logic [13:0] d;
        logic        ia;
        int st, wc;
        cpu_write(14'h3F0E, 14'h0002, st);
        cpu_read(14'h3F0E, d, st);
        n_chk++;
        if (d !== 14'h0002) begin n_fail++; $display("FAIL mask_readback got=%h required 0002", d); end
        rx_send(14'h3FFE, 3'd1, wc, ia);
        n_chk++;
        if (ia !== 1'b0 || irq !== 1'b1) begin
            n_fail++; $display("FAIL irq_rise at_done=%b next=%b required 0 then 1", ia, irq);
        end
        cpu_read(14'h3F02, d, st);
        n_chk++;
        if (d !== 14'h3FFE) begin n_fail++; $display("FAIL rx1_data got=%h required 3FFE", d); end
        @(negedge Clk_pin); @(posedge Clk_pin); #1;
        n_chk++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear irq=%b required 0", irq); end
        rx_send(14'h0555, 3'd0, wc, ia);
        @(negedge Clk_pin);
        n_chk++;
        if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked irq=%b required 0", irq); end
        cpu_read(14'h3F00, d, st);
        n_chk++;
        if (d !== 14'h0555) begin n_fail++; $display("FAIL rx0_masked_data got=%h required 0555", d); end
    endtask

    task automatic test_rx_stall();
        logic [13:0] d;
        logic        ia;
        int st, wc;
        fork
            cpu_read(14'h3F00, d, st);
            begin
                repeat (4) @(negedge Clk_pin);
                rx_send(14'h2AAA, 3'd0, wc, ia);
            end
        join
        n_chk++;
        if (st < 4 || d !== 14'h2AAA) begin
            n_fail++; $display("FAIL rx_empty_stall stalls=%0d data=%h required >=4 and 2AAA", st, d);
        end
    endtask

    task automatic test_rx_full();
        logic [13:0] d;
        logic        ia;
        int st, wc;
        for (int i = 0; i < 4; i++) rx_send(14'h0010 + 14'(i), 3'd0, wc, ia);
        cpu_read(14'h3F01, d, st);
        n_chk++;
        if (d !== 14'h0013) begin n_fail++; $display("FAIL rx0_full_stat got=%h required 0013", d); end
        fork
            rx_send(14'h0014, 3'd0, wc, ia);
            begin
                repeat (6) @(negedge Clk_pin);
                #1;
                n_chk++;
                if (link_rx_done !== 1'b0) begin
                    n_fail++; $display("FAIL rx_backpressure done=%b required 0", link_rx_done);
                end
                cpu_read(14'h3F00, d, st);
            end
        join
        n_chk++;
        if (d !== 14'h0010 || wc <= 6) begin
            n_fail++; $display("FAIL rx_full_release pop=%h wait=%0d required 0010 and >6", d, wc);
        end
        for (int i = 1; i < 5; i++) begin
            cpu_read(14'h3F00, d, st);
            n_chk++;
            if (d !== 14'h0010 + 14'(i)) begin
                n_fail++; $display("FAIL rx0_drain%0d got=%h required %h", i, d, 14'h0010 + 14'(i));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [13:0] d;
        int st, n;
        cpu_write(14'h3F00, 14'h0777, st);
        n = 0;
        while (!link_tx_valid && n < 50) begin @(negedge Clk_pin); n++; end
        @(negedge Clk_pin);
        Reset_pin = 1'b1;
        @(posedge Clk_pin); #1;
        n_chk++;
        if (link_tx_valid !== 1'b0 || link_tx_data !== 14'h0) begin
            n_fail++; $display("FAIL reset_mid_tx valid=%b data=%h required 0/0000", link_tx_valid, link_tx_data);
        end
        @(negedge Clk_pin);
        Reset_pin = 1'b0;
        cpu_read(14'h3F01, d, st);
        n_chk++;
        if (d !== 14'h0002) begin n_fail++; $display("FAIL reset_mid_stat0 got=%h required 0002", d); end
        cpu_read(14'h3F03, d, st);
        n_chk++;
        if (d !== 14'h0002) begin n_fail++; $display("FAIL reset_mid_stat1 got=%h required 0002", d); end
        cpu_read(14'h3F0E, d, st);
        n_chk++;
        if (d !== 14'h0000) begin n_fail++; $display("FAIL reset_mid_mask got=%h required 0000", d); end
        repeat (3) @(negedge Clk_pin);
        n_chk++;
        if (link_tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid_idle valid=%b required 0", link_tx_valid); end
    endtask

    initial begin
        Reset_pin = 1'b1;
        cpu_addr = '0; cpu_wdata = '0; cpu_wr = 1'b0; cpu_rd = 1'b0;
        link_tx_done = 1'b0; link_rx_data = '0; link_rx_ch = '0; link_rx_valid = 1'b0;
        test_reset();
        test_tx_basic();
        test_tx_stall();
        test_round_robin();
        test_rx_irq();
        test_rx_stall();
        test_rx_full();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ahf_mbox_link.md
Name: ahf_mbox_link

Overview:
- Parametrised multi-channel mailbox between a RISC521 core's memory-mapped I/O window (0x3F00–0x3F0E) and an inter-core link.
- Generalises the single-word Read/Write/Done port into NCH independent channels, each with TX and RX FIFOs of depth DEPTH.
- Blocking accesses stall the core pipeline.
- Link side uses a four-phase valid/done handshake with round-robin TX arbitration.

Parameters:
- DW, 14, data and address width.
- NCH, 2, channel count, 1..7.
- DEPTH, 4, entries per FIFO, one of 2/4/8.
- BASE, 8'h3F, value of cpu_addr[13:8] that selects the block.

Ports:
- Clk_pin  in  1  single clock; all state updates on rising edge.
- Reset_pin  in  1  synchronous, active-high reset.
- cpu_addr  in  DW  effective address from MC2/MC3.
- cpu_wr  in  1  store strobe.
- cpu_rd  in  1  load strobe.
- cpu_wdata  in  DW  store data.
- cpu_rdata  out  DW  load data, registered.
- cpu_stall  out  1  combinational stall request to the core.
- link_tx_data  out  DW  outgoing word.
- link_tx_ch  out  3  outgoing channel number.
- link_tx_valid  out  1  outgoing request.
- link_tx_done  in  1  remote acknowledge.
- link_rx_data  in  DW  incoming word.
- link_rx_ch  in  3  incoming channel number.
- link_rx_valid  in  1  incoming request.
- link_rx_done  out  1  local acknowledge.
- irq  out  1  masked RX-not-empty interrupt.

Behaviour:
- Reset (sync, Reset_pin=1 at edge): all FIFOs empty, pointers 0, irq_mask=0, round-robin pointer=0. cpu_rdata=0, link_tx_valid=0, link_tx_data=0, link_tx_ch=0, link_rx_done=0, irq=0. Both FSMs go to IDLE.
- Reset mid-handshake: the in-flight word is discarded. The remote must observe valid/done drop.
- Selection: cpu_addr[13:8]==BASE.
  - Offset 2c (c<NCH): DATA_c. Write pushes TX_c; read pops RX_c.
  - Offset 2c+1: STAT_c, read-only.
  - Offset 0xE: IRQ_MASK, bits [NCH-1:0] R/W.
  - Offset 0xF is SP and is not decoded.
- Other offsets inside the window: read returns 0, write ignored, no stall. Unselected addresses: no effect, cpu_rdata holds.
- STAT_c layout:
  - [0] RX_c non-empty.
  - [1] TX_c not full.
  - [5:2] RX_c count.
  - [9:6] TX_c count.
  - [13:10] 0.
- cpu_stall=1 when either:
  - cpu_wr to DATA_c with TX_c full, or
  - cpu_rd from DATA_c with RX_c empty.
- While stalled, the core holds addr/strobes/wdata stable. The access completes on the first edge where stall is 0.
- cpu_rdata is loaded on the completing edge, so data is valid the cycle after acceptance. Pop and push take effect on the same edge.
- Same-cycle push and pop on one FIFO: both occur and the count is unchanged.
- Full/empty are evaluated from pre-edge state. There is no bypass: a push to a full FIFO is never accepted in the same cycle as a pop.
- TX FSM:
  - IDLE: if any TX FIFO is non-empty, pick the first non-empty channel at or after rr_ptr (wrapping). Drive data and channel, assert link_tx_valid, go to REQ.
  - REQ: hold valid, data and channel. When link_tx_done=1, pop that FIFO, drop valid, set rr_ptr=ch+1 mod NCH, go to WAIT_LOW.
  - WAIT_LOW: when link_tx_done=0, go to IDLE.
  - Minimum 3 cycles per word.
- RX FSM:
  - IDLE: if link_rx_valid=1, link_rx_ch<NCH and RX_ch is not full, push link_rx_data, assert link_rx_done, go to ACK.
  - If RX_ch is full: withhold done (backpressure) and stay in IDLE.
  - If link_rx_ch>=NCH: accept and discard the word with done asserted.
  - ACK: hold done=1 until link_rx_valid=0, then done=0 and go to IDLE.
- irq is registered: irq = |(RX non-empty vector & irq_mask), updated every edge.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. Counts are 0..DEPTH.

Test Plan:
- Reset, then read STAT_0 (0x3F01) → cpu_rdata=14'h0002 one cycle later. Link outputs 0, no stall.
- Write 14'h1234, 14'h0ABC to 0x3F00; remote acks each with a 2-cycle done delay → link_tx_data 1234 then 0ABC on ch0, valid low between words, STAT_0 returns to 0002.
- Fill TX1 with 4 words (no acks), 5th write to 0x3F02 → cpu_stall=1. Stall stays high until the first remote ack completes; the 5th word is accepted on the next edge.
- Pre-load TX0 and TX1 with 2 words each → link transmit order is ch0, ch1, ch0, ch1.
- Remote sends 14'h3FFE on ch1 with IRQ_MASK=2'b10 → link_rx_done pulses and irq=1 the next cycle. Read 0x3F02 returns 3FFE and irq clears.
- Read 0x3F00 with RX0 empty → stall holds. A remote push on ch0 releases the stall; cpu_rdata equals the pushed word.
- Fill RX0 (4 words), 5th remote send → link_rx_done stays 0 until a CPU pop, then the word is accepted.
- Assert Reset_pin during TX REQ → link_tx_valid=0 after that edge and all STAT registers read reset values.
